// File: rtl/io_map_vga_btn.sv
// ============================================================================
// io_map_vga_btn
//
// Pin-level I/O mapper for the tile.
//   * Drives the TinyVGA Pmod on uo_out from the video core's colour/sync.
//   * Conditions up to 8 active-low push buttons on ui_in. Each button has:
//       - a 2-FF synchroniser (s1 -> s2),
//       - a counter debouncer that only accepts a new level after it has been
//         seen for DEBOUNCE_CYCLES consecutive cycles,
//       - a debounced level output plus one-cycle press/release pulses.
//   * Colour is forced to 0 outside the active video area; sync is never gated.
//
// Optional build macro:
//   IO_MAP_REG_OUT_EN  defined   -> uo_out is registered (1-cycle latency,
//                                   cleared by rst).
//                      undefined -> uo_out is purely combinational, rst has
//                                   no effect on it.
//   The button path is identical in both builds.
//
// Parameters:
//   NUM_BTN          number of buttons on ui_in[NUM_BTN-1:0], 1..8
//   DEBOUNCE_CYCLES  consecutive stable cycles before a level is accepted, >=2
//
// Ports:
//   clk          in   1        tile clock
//   rst          in   1        synchronous, active-high reset
//   ena          in   1        tile enable, ignored
//   ui_in        in   8        dedicated inputs, buttons active-low on [NUM_BTN-1:0]
//   uo_out       out  8        {hs,b0,g0,r0,vs,b1,g1,r1}, TinyVGA Pmod order
//   uio_in       in   8        ignored
//   uio_out      out  8        constant 0
//   uio_oe       out  8        constant 0 (all bidirectionals are inputs)
//   btn          out  NUM_BTN  debounced level, 1 = pressed
//   btn_press    out  NUM_BTN  1-cycle pulse on debounced 0->1
//   btn_release  out  NUM_BTN  1-cycle pulse on debounced 1->0
//   r, g, b      in   2 each   colour from the video core
//   hs, vs       in   1 each   sync from the video core, native polarity
//   de           in   1        active video; 0 blanks the colour pins
// ============================================================================
module io_map_vga_btn #(
    parameter int NUM_BTN         = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [7:0]         ui_in,
    output logic [7:0]         uo_out,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    output logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    input  logic [1:0]         r,
    input  logic [1:0]         g,
    input  logic [1:0]         b,
    input  logic               hs,
    input  logic               vs,
    input  logic               de
);

    // Counter just wide enough to reach DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser stages and the accepted raw (active-low) level per button.
    logic [NUM_BTN-1:0] s1;
    logic [NUM_BTN-1:0] s2;
    logic [NUM_BTN-1:0] stable_n;
    logic [CNT_W-1:0]   cnt [NUM_BTN];

    // Colour/sync in pin order before the optional output register.
    logic [7:0] pins;

    // The bidirectional bank is not used by this tile: keep every pin an
    // input and drive nothing, including while in reset.
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Inputs that are deliberately ignored are folded into one signal so the
    // intent is explicit; nothing consumes it.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in};

    // Two-flop synchroniser. Reset preloads the released level (1) so a
    // button held through reset has to travel the full path again and is
    // seen as a fresh press once rst drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= ui_in[NUM_BTN-1:0];
            s2 <= s1;
        end
    end

    // Counter debouncer. A button's counter only runs while the synchronised
    // level disagrees with the accepted one; any cycle of agreement (a
    // bounce back) clears it, so acceptance needs DEBOUNCE_CYCLES consecutive
    // disagreeing samples. The press/release pulses are registered at the
    // same edge that updates stable_n, so each is exactly one cycle long and
    // lines up with the change on btn. Because a single acceptance flips the
    // level one way only, press and release can never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_n    <= '1;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (s2[i] == stable_n[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable_n[i]    <= s2[i];
                    cnt[i]         <= '0;
                    btn_press[i]   <= ~s2[i];
                    btn_release[i] <= s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Buttons are active-low on the pins; present them active-high.
    assign btn = ~stable_n;

    // Video pin mapping. TinyVGA numbers the colour bits with 1 as the MSB
    // and 0 as the LSB, so the LSBs go to the upper nibble and the MSBs to
    // the lower nibble. Outside active video the colour bits are blanked,
    // but sync is always passed through untouched.
    always_comb begin
        pins = {hs, 3'b000, vs, 3'b000};
        if (de) begin
            pins = {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
        end
    end

`ifdef IO_MAP_REG_OUT_EN
    // Registered output: one cycle of latency on every pin, cleared in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            uo_out <= 8'h00;
        end else begin
            uo_out <= pins;
        end
    end
`else
    // Combinational output: pins follow the video inputs with no latency.
    assign uo_out = pins;
`endif

endmodule

// File: tb/tb_io_map_vga_btn.sv
// ============================================================================
// tb_io_map_vga_btn
//
// Directed self-checking bench for io_map_vga_btn with NUM_BTN=2 and
// DEBOUNCE_CYCLES=4. Follows the IO_MAP_REG_OUT_EN macro for the expected
// video timing. Inputs change 1 time unit after a rising edge; outputs are
// sampled 1 time unit after a rising edge (or just after an input change for
// the combinational video path).
// ============================================================================
module tb_io_map_vga_btn;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [1:0] btn;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
    logic       de;

    int checks;
    int errors;

    io_map_vga_btn #(
        .NUM_BTN        (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .uio_in     (uio_in),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .btn        (btn),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .r          (r),
        .g          (g),
        .b          (b),
        .hs         (hs),
        .vs         (vs),
        .de         (de)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held with button 0 pressed: everything reads released and quiet.
    task automatic test_reset();
        rst = 1'b1;
        ui_in = 8'hFE;
        r = 2'd3; g = 2'd3; b = 2'd3; hs = 1'b1; vs = 1'b1; de = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (btn !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_btn got %b expected 00", btn);
        end
        checks++;
        if (btn_press !== 2'b00 || btn_release !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_pulses got press %b release %b expected 00 00",
                     btn_press, btn_release);
        end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_uio got out %h oe %h expected 00 00", uio_out, uio_oe);
        end
`ifdef IO_MAP_REG_OUT_EN
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_uo_out got %h expected 00", uo_out);
        end
`endif
        rst = 1'b0;
        ui_in = 8'hFF;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (btn !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_btn got %b expected 00", btn);
        end
    endtask

    // Clean press on button 0: accepted on the 6th edge with a single pulse.
    task automatic test_press();
        ui_in = 8'hFE;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (btn !== ((k >= 6) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL press_btn edge %0d got %b expected %b",
                         k, btn, (k >= 6) ? 2'b01 : 2'b00);
            end
            checks++;
            if (btn_press !== ((k == 6) ? 2'b01 : 2'b00) || btn_release !== 2'b00) begin
                errors++;
                $display("[TB] FAIL press_pulse edge %0d got press %b release %b expected %b 00",
                         k, btn_press, btn_release, (k == 6) ? 2'b01 : 2'b00);
            end
        end
    endtask

    // Clean release on button 0: accepted on the 6th edge with a release pulse.
    task automatic test_release();
        ui_in = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (btn !== ((k >= 6) ? 2'b00 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL release_btn edge %0d got %b expected %b",
                         k, btn, (k >= 6) ? 2'b00 : 2'b01);
            end
            checks++;
            if (btn_release !== ((k == 6) ? 2'b01 : 2'b00) || btn_press !== 2'b00) begin
                errors++;
                $display("[TB] FAIL release_pulse edge %0d got release %b press %b expected %b 00",
                         k, btn_release, btn_press, (k == 6) ? 2'b01 : 2'b00);
            end
        end
    endtask

    // Low 3, high 1, then low: the bounce clears progress, so the level is
    // only accepted after 4 consecutive low samples (edges 5..8 -> edge 10).
    task automatic test_bounce();
        for (int k = 1; k <= 12; k++) begin
            ui_in = (k == 4) ? 8'hFF : 8'hFE;
            tick();
            checks++;
            if (btn !== ((k >= 10) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL bounce_btn edge %0d got %b expected %b",
                         k, btn, (k >= 10) ? 2'b01 : 2'b00);
            end
            checks++;
            if (btn_press !== ((k == 10) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL bounce_press edge %0d got %b expected %b",
                         k, btn_press, (k == 10) ? 2'b01 : 2'b00);
            end
        end
    endtask

    // Video mapping: {hs,b0,g0,r0,vs,b1,g1,r1}, colour blanked when de=0.
    task automatic test_video();
        logic [1:0] vr [4];
        logic [1:0] vg [4];
        logic [1:0] vb [4];
        logic       vhs[4];
        logic       vvs[4];
        logic       vde[4];
        logic [7:0] vexp[4];
        vr[0] = 2'd3; vg[0] = 2'd2; vb[0] = 2'd1; vhs[0] = 1'b1; vvs[0] = 1'b0; vde[0] = 1'b1; vexp[0] = 8'hD3;
        vr[1] = 2'd3; vg[1] = 2'd2; vb[1] = 2'd1; vhs[1] = 1'b1; vvs[1] = 1'b0; vde[1] = 1'b0; vexp[1] = 8'h80;
        vr[2] = 2'd0; vg[2] = 2'd1; vb[2] = 2'd2; vhs[2] = 1'b0; vvs[2] = 1'b1; vde[2] = 1'b1; vexp[2] = 8'h2C;
        vr[3] = 2'd3; vg[3] = 2'd3; vb[3] = 2'd3; vhs[3] = 1'b1; vvs[3] = 1'b1; vde[3] = 1'b0; vexp[3] = 8'h88;
        for (int i = 0; i < 4; i++) begin
            r = vr[i]; g = vg[i]; b = vb[i]; hs = vhs[i]; vs = vvs[i]; de = vde[i];
`ifdef IO_MAP_REG_OUT_EN
            tick();
`else
            #1;
`endif
            checks++;
            if (uo_out !== vexp[i]) begin
                errors++;
                $display("[TB] FAIL video_%0d uo_out got %h expected %h", i, uo_out, vexp[i]);
            end
`ifndef IO_MAP_REG_OUT_EN
            tick();
`endif
        end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("[TB] FAIL video_uio got out %h oe %h expected 00 00", uio_out, uio_oe);
        end
    endtask

    // Both buttons pressed together, reset pulsed at edge 3: progress is
    // discarded and both are accepted together on the 6th edge after reset.
    task automatic test_simul_reset();
        ui_in = 8'hFC;
        for (int k = 1; k <= 2; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (btn !== 2'b00 || btn_press !== 2'b00) begin
            errors++;
            $display("[TB] FAIL simul_in_reset got btn %b press %b expected 00 00", btn, btn_press);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (btn !== ((k >= 6) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL simul_btn edge %0d got %b expected %b",
                         k, btn, (k >= 6) ? 2'b11 : 2'b00);
            end
            checks++;
            if (btn_press !== ((k == 6) ? 2'b11 : 2'b00) || btn_release !== 2'b00) begin
                errors++;
                $display("[TB] FAIL simul_pulse edge %0d got press %b release %b expected %b 00",
                         k, btn_press, btn_release, (k == 6) ? 2'b11 : 2'b00);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        ena    = 1'b1;
        uio_in = 8'hA5;
        ui_in  = 8'hFF;
        r = 2'd0; g = 2'd0; b = 2'd0; hs = 1'b0; vs = 1'b0; de = 1'b0;
        #2;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_release();
        test_video();
        test_simul_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
